mem2_pipe_ctrl: RTL and testbench

- Sequences the MEM -> MEM2 pipeline boundary around data-cache accesses.
- Issues the DCache request for the instruction in MEM and holds that instruction (stalls MEM and everything upstream) until the cache acknowledges.
- Drives MEM2_Wr/MEM2_Flush so MEM2 receives a bubble, never a duplicate, while stalled.
- Handles exception commits from MEM2, including draining a cache response already in flight; also keeps a saturating stall-cycle performance counter.

---
 rtl/mem2_pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_mem2_pipe_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem2_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// mem2_pipe_ctrl
//
// Controls the MEM -> MEM2 pipeline boundary around data-cache accesses.
// The controller issues the DCache request for the load/store sitting in MEM.
// It holds MEM and all upstream stages until the cache returns data or a
// write ack. While MEM is held, MEM2 is fed bubbles.
// An exception commit from MEM2 kills the in-flight access. If the cache has
// already accepted that access, the controller parks in DRAIN until the
// orphaned response arrives. This keeps a late DataOk from being credited to
// the next instruction.
// A saturating counter records the total number of stall cycles.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous, active-low reset
//   MEM_MemReq       valid load/store in MEM needs a DCache access
//   MEM_IsWrite      MEM access is a store (stable while stalled)
//   MEM_Exc          MEM instruction carries an exception; suppresses access
//   Exc_Commit       exception/eret committing in MEM2; kills MEM and younger
//   DCache_ReqReady  DCache accepts the request this cycle
//   DCache_DataOk    read data / write ack returned
//   Cnt_Clear        synchronous clear of Stall_Cnt
//   DCache_Req       request valid to DCache
//   DCache_Wr        request is a write
//   MEM_Wr/MEM_Flush     MEM register write enable / flush
//   MEM2_Wr/MEM2_Flush   MEM2 register write enable / flush (flush wins)
//   Stall_Up         hold IF/ID/EXE registers
//   Ctrl_State       current state (debug): IDLE=0 REQ=1 WAIT=2 DRAIN=3
//   Stall_Cnt        saturating count of stall cycles since reset/clear
// -----------------------------------------------------------------------------
module mem2_pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MEM_MemReq,
  input  logic             MEM_IsWrite,
  input  logic             MEM_Exc,
  input  logic             Exc_Commit,
  input  logic             DCache_ReqReady,
  input  logic             DCache_DataOk,
  input  logic             Cnt_Clear,
  output logic             DCache_Req,
  output logic             DCache_Wr,
  output logic             MEM_Wr,
  output logic             MEM_Flush,
  output logic             MEM2_Wr,
  output logic             MEM2_Flush,
  output logic             Stall_Up,
  output logic [1:0]       Ctrl_State,
  output logic [CNT_W-1:0] Stall_Cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t state;
  logic   start;
  logic   stall;
  logic   req;

  // NOTE: every signal gets a value at the top of always_comb, so no path
  // through the block can leave one unassigned and infer a latch.
  always_comb begin
    start = 1'b0;
    req   = 1'b0;
    stall = 1'b0;
    start = MEM_MemReq & ~MEM_Exc & ~Exc_Commit;
    req   = ((state == S_IDLE) & start) | ((state == S_REQ) & ~Exc_Commit);
    // The completion cycle (WAIT with DataOk) is not a stall. The instruction
    // moves into MEM2 on that edge.
    stall = ((state == S_IDLE) & start)
          | (state == S_REQ)
          | ((state == S_WAIT) & ~DCache_DataOk)
          | (state == S_DRAIN);
  end

  // NOTE: the pipeline controls are combinational, so they are masked with
  // rst explicitly. Register reset alone would leave MEM_Wr/MEM2_Wr high
  // while the core is held in reset.
  assign DCache_Req = rst & req;
  assign DCache_Wr  = rst & MEM_IsWrite;
  assign MEM_Wr     = rst & ~stall;
  assign MEM2_Wr    = rst & ~stall;
  assign MEM_Flush  = rst & Exc_Commit;
  // A bubble enters MEM2 while MEM is held, so the held instruction never
  // commits twice.
  assign MEM2_Flush = rst & (stall | Exc_Commit);
  // The redirect fetched after an exception must be allowed to advance.
  assign Stall_Up   = rst & stall & ~Exc_Commit;
  assign Ctrl_State = state;

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // pre-edge values no matter which order the blocks evaluate in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= DCache_ReqReady ? S_WAIT : S_REQ;
        end
        S_REQ: begin
          // If the cache accepted the request in the same cycle as the
          // commit, the response still arrives later and has to be drained.
          if (DCache_ReqReady) state <= Exc_Commit ? S_DRAIN : S_WAIT;
          else if (Exc_Commit) state <= S_IDLE;
        end
        S_WAIT: begin
          // DataOk in the commit cycle needs no drain. The flush discards
          // the response.
          if (DCache_DataOk)   state <= S_IDLE;
          else if (Exc_Commit) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (DCache_DataOk) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Stall_Cnt <= '0;
    end else if (Cnt_Clear) begin
      Stall_Cnt <= '0;
    end else if (stall && (Stall_Cnt != {CNT_W{1'b1}})) begin
      Stall_Cnt <= Stall_Cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem2_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for mem2_pipe_ctrl.
// The bench drives two instances from the same stimulus: the default 32-bit
// counter and a 3-bit counter used to exercise saturation.
// A transaction-level model tracks the access in MEM:
//   - pending: the request has not been accepted yet
//   - outstanding: the request was accepted and its response is still due
//   - doomed: the response will be discarded
// Each cycle, the model checks every DUT output. Directed sequences then pin
// the model with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_mem2_pipe_ctrl;

  logic clk;
  logic rst;
  logic MEM_MemReq, MEM_IsWrite, MEM_Exc, Exc_Commit;
  logic DCache_ReqReady, DCache_DataOk, Cnt_Clear;

  logic        DCache_Req, DCache_Wr, MEM_Wr, MEM_Flush, MEM2_Wr, MEM2_Flush, Stall_Up;
  logic [1:0]  Ctrl_State;
  logic [31:0] Stall_Cnt;

  logic        DCache_Req_3, DCache_Wr_3, MEM_Wr_3, MEM_Flush_3, MEM2_Wr_3, MEM2_Flush_3, Stall_Up_3;
  logic [1:0]  Ctrl_State_3;
  logic [2:0]  Stall_Cnt_3;

  int vectors;
  int miscompares;

  // Transaction-level model state.
  bit     m_pending;
  bit     m_outstanding;
  bit     m_doomed;
  longint m_cnt;       // stall cycles since last clear/reset (unsaturated)
  bit     m_start;
  bit     m_stall;

  mem2_pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .MEM_MemReq(MEM_MemReq), .MEM_IsWrite(MEM_IsWrite), .MEM_Exc(MEM_Exc),
    .Exc_Commit(Exc_Commit), .DCache_ReqReady(DCache_ReqReady),
    .DCache_DataOk(DCache_DataOk), .Cnt_Clear(Cnt_Clear),
    .DCache_Req(DCache_Req), .DCache_Wr(DCache_Wr), .MEM_Wr(MEM_Wr),
    .MEM_Flush(MEM_Flush), .MEM2_Wr(MEM2_Wr), .MEM2_Flush(MEM2_Flush),
    .Stall_Up(Stall_Up), .Ctrl_State(Ctrl_State), .Stall_Cnt(Stall_Cnt)
  );

  mem2_pipe_ctrl #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst),
    .MEM_MemReq(MEM_MemReq), .MEM_IsWrite(MEM_IsWrite), .MEM_Exc(MEM_Exc),
    .Exc_Commit(Exc_Commit), .DCache_ReqReady(DCache_ReqReady),
    .DCache_DataOk(DCache_DataOk), .Cnt_Clear(Cnt_Clear),
    .DCache_Req(DCache_Req_3), .DCache_Wr(DCache_Wr_3), .MEM_Wr(MEM_Wr_3),
    .MEM_Flush(MEM_Flush_3), .MEM2_Wr(MEM2_Wr_3), .MEM2_Flush(MEM2_Flush_3),
    .Stall_Up(Stall_Up_3), .Ctrl_State(Ctrl_State_3), .Stall_Cnt(Stall_Cnt_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] bundle3();
    return {DCache_Req_3, DCache_Wr_3, MEM_Wr_3, MEM_Flush_3, MEM2_Wr_3,
            MEM2_Flush_3, Stall_Up_3, Ctrl_State_3};
  endfunction

  function automatic logic [1:0] model_state();
    if (m_pending)     return 2'd1;
    if (m_outstanding) return m_doomed ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  // Compares every output against the model for the inputs applied this cycle.
  task automatic compare_all();
    bit         idle;
    bit         e_req;
    logic [1:0] e_st;
    logic [8:0] e_bundle;
    idle    = !m_pending && !m_outstanding;
    m_start = MEM_MemReq && !MEM_Exc && !Exc_Commit;
    // Stalled whenever the access in MEM is not finishing this cycle.
    m_stall = (idle && m_start) || m_pending ||
              (m_outstanding && (m_doomed || !DCache_DataOk));
    e_req   = (idle && m_start) || (m_pending && !Exc_Commit);
    e_st    = model_state();
    check("DCache_Req", DCache_Req, e_req);
    check("DCache_Wr",  DCache_Wr,  MEM_IsWrite);
    check("MEM_Wr",     MEM_Wr,     !m_stall);
    check("MEM_Flush",  MEM_Flush,  Exc_Commit);
    check("MEM2_Wr",    MEM2_Wr,    !m_stall);
    check("MEM2_Flush", MEM2_Flush, m_stall || Exc_Commit);
    check("Stall_Up",   Stall_Up,   m_stall && !Exc_Commit);
    check("Ctrl_State", Ctrl_State, e_st);
    check("Stall_Cnt",  Stall_Cnt,  m_cnt[31:0]);
    e_bundle = {e_req, MEM_IsWrite, !m_stall, Exc_Commit, !m_stall,
                m_stall || Exc_Commit, m_stall && !Exc_Commit, e_st};
    check("dut3_ctrl",  bundle3(),  e_bundle);
    check("Stall_Cnt_3", Stall_Cnt_3, (m_cnt > 7) ? 64'd7 : m_cnt);
  endtask

  task automatic model_advance();
    if (m_outstanding) begin
      if (DCache_DataOk) begin
        m_outstanding = 0;
        m_doomed      = 0;
      end else if (Exc_Commit) begin
        m_doomed = 1;
      end
    end else if (m_pending || m_start) begin
      if (DCache_ReqReady) begin
        m_pending     = 0;
        m_outstanding = 1;
        m_doomed      = Exc_Commit;
      end else begin
        m_pending = !Exc_Commit;
      end
    end
    if (Cnt_Clear)    m_cnt = 0;
    else if (m_stall) m_cnt = m_cnt + 1;
  endtask

  task automatic model_reset();
    m_pending = 0; m_outstanding = 0; m_doomed = 0; m_cnt = 0;
  endtask

  // One clock cycle: drive just after the rising edge, check on the falling
  // edge. Returns at the falling edge so callers can add literal checks.
  task automatic step(input bit mreq, input bit wr, input bit exc, input bit commit,
                      input bit rdy, input bit ok, input bit clr);
    @(posedge clk);
    #1;
    MEM_MemReq = mreq; MEM_IsWrite = wr; MEM_Exc = exc; Exc_Commit = commit;
    DCache_ReqReady = rdy; DCache_DataOk = ok; Cnt_Clear = clr;
    @(negedge clk);
    compare_all();
    model_advance();
  endtask

  task automatic idle_inputs();
    MEM_MemReq = 0; MEM_IsWrite = 0; MEM_Exc = 0; Exc_Commit = 0;
    DCache_ReqReady = 0; DCache_DataOk = 0; Cnt_Clear = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bits"}, {DCache_Req, DCache_Wr, MEM_Wr, MEM_Flush, MEM2_Wr,
                           MEM2_Flush, Stall_Up}, 0);
    check({tag, "_state"}, Ctrl_State, 0);
    check({tag, "_cnt"}, Stall_Cnt, 0);
    check({tag, "_dut3"}, bundle3(), 0);
    check({tag, "_cnt3"}, Stall_Cnt_3, 0);
  endtask

  initial begin
    bit         wr;
    logic [1:0] exp_seq [7];
    vectors = 0;
    miscompares = 0;
    model_reset();
    rst = 1'b0;
    idle_inputs();
    MEM_MemReq = 1;  // must stay invisible while in reset
    MEM_IsWrite = 1;
    #12;
    check_reset_outputs("por");
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;

    // Load: accepted in cycle 0, data in cycle 1.
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0, 0);
    check("t1_c0_req",    DCache_Req, 1);
    check("t1_c0_m2fl",   MEM2_Flush, 1);
    check("t1_c0_m2wr",   MEM2_Wr,    0);
    step(1, 0, 0, 0, 0, 1, 0);
    check("t1_c1_req",    DCache_Req, 0);
    check("t1_c1_m2wr",   MEM2_Wr,    1);
    check("t1_c1_m2fl",   MEM2_Flush, 0);
    check("t1_c1_cnt",    Stall_Cnt,  1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("t1_after_st",  Ctrl_State, 0);

    // Store: ReqReady low for three cycles, DataOk two cycles after accept.
    step(0, 0, 0, 0, 0, 0, 1);
    exp_seq = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    for (int c = 0; c < 7; c++) begin
      if (c < 6) step(1, 1, 0, 0, c == 3, c == 5, 0);
      else       step(0, 1, 0, 0, 0, 0, 0);
      check($sformatf("t2_state_c%0d", c), Ctrl_State, exp_seq[c]);
      check($sformatf("t2_wr_c%0d", c), DCache_Wr, 1);
    end
    check("t2_cnt", Stall_Cnt, 5);

    // An excepting access passes with no request and no stall.
    step(1, 0, 1, 0, 1, 0, 0);
    check("t3_req",   DCache_Req, 0);
    check("t3_m2wr",  MEM2_Wr,    1);
    check("t3_stall", Stall_Up,   0);

    // Commit during WAIT, response three cycles late.
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    check("t4_memfl",  MEM_Flush,  1);
    check("t4_m2fl",   MEM2_Flush, 1);
    check("t4_up",     Stall_Up,   0);
    for (int c = 0; c < 3; c++) begin
      step(1, 0, 0, 0, 1, c == 2, 0);
      check($sformatf("t4_drain_c%0d", c), Ctrl_State, 3);
      check($sformatf("t4_noreq_c%0d", c), DCache_Req, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    check("t4_idle", Ctrl_State, 0);

    // Commit in REQ: withdrawn without ReqReady, drained with it.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    check("t5a_req", DCache_Req, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("t5a_state", Ctrl_State, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0);
    check("t5b_req", DCache_Req, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check("t5b_state", Ctrl_State, 3);
    step(0, 0, 0, 0, 0, 0, 0);
    check("t5b_idle", Ctrl_State, 0);

    // Saturation of the 3-bit counter, clear during a stall, reset mid-WAIT.
    step(0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 9; c++) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    check("t6_sat3",  Stall_Cnt_3, 7);
    check("t6_cnt32", Stall_Cnt,   9);
    step(1, 0, 0, 0, 1, 0, 0);
    check("t6_clr3",  Stall_Cnt_3, 0);
    check("t6_clr32", Stall_Cnt,   0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("t6_wait", Ctrl_State, 2);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the model.
    wr = 0;
    for (int n = 0; n < 2000; n++) begin
      bit busy, mreq, exc, commit, rdy, ok, clr;
      busy   = m_pending || m_outstanding;
      if (!busy) wr = ($urandom_range(0, 1) == 1);
      mreq   = ($urandom_range(0, 9) < 6);
      exc    = ($urandom_range(0, 9) == 0);
      commit = ($urandom_range(0, 99) < 8);
      rdy    = ($urandom_range(0, 1) == 1);
      ok     = m_outstanding && ($urandom_range(0, 9) < 3);
      clr    = ($urandom_range(0, 99) < 2);
      step(mreq, wr, exc, commit, rdy, ok, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
